ctrl_seq: RTL and testbench
===========================

# ctrl_seq

Fetch/execute sequencer for the 4-bit accumulator datapath. Drives the program counter and produces the one-cycle set strobes and operand that feed the datapath's general-purpose registers: instruction, accumulator and output latch. It sits directly upstream of those registers, which capture their data on the rising clock edge while their set input is high. Each instruction takes exactly two cycles, FETCH then EXEC.

## Interface
- DATA_WIDTH, 4, accumulator/operand width (operand field is 4 bits; zero-extended or truncated to DATA_WIDTH)
- PC_WIDTH, 4, program counter width
- clock_in  input  1  single clock; all state changes on its rising edge
- reset_n_in  input  1  asynchronous, active-low reset
- run_in  input  1  level enable; sequencer leaves IDLE only while high
- instr_in  input  8  program memory word at pc_out; [7:4] opcode, [3:0] operand
- acc_zero_in  input  1  high when accumulator == 0
- pc_out  output  PC_WIDTH  program counter (registered)
- ir_set_out  output  1  instruction-register load strobe
- acc_set_out  output  1  accumulator load strobe
- acc_src_out  output  2  accumulator source: 00 operand, 01 acc+operand, 10 acc-operand, 11 input port
- out_set_out  output  1  output-latch load strobe
- operand_out  output  DATA_WIDTH  operand field of latched instruction
- state_out  output  2  IDLE=00, FETCH=01, EXEC=10, HALT=11
- halted_out  output  1  high in HALT

## Operation
- Internal IR (8 bits) latches instr_in on every FETCH cycle. operand_out = IR[3:0], resized to DATA_WIDTH.
- Opcodes: 0 NOP, 1 LDI (acc_src 00), 2 ADD (01), 3 SUB (10), 4 IN (11), 5 OUT, 6 JMP, 7 JZ, F HLT; 8-E decode as NOP.
- IDLE: all strobes low. Goes to FETCH when run_in=1; otherwise stays.
- FETCH: ir_set_out=1. Always goes to EXEC.
- EXEC: decoded from IR, combinational from state+IR:
  - LDI/ADD/SUB/IN: acc_set_out=1 for one cycle, with acc_src_out as above.
  - OUT: out_set_out=1.
  - JMP: pc <= operand, resized to PC_WIDTH.
  - JZ: pc <= operand if acc_zero_in=1 (sampled in EXEC); else pc+1.
  - HLT: next state HALT; pc is not incremented.
  - All other opcodes: pc <= pc+1, wrapping from 2^PC_WIDTH-1 to 0.
  - Next state: FETCH if run_in=1, IDLE if run_in=0 (HLT overrides both).
- HALT: sticky; all strobes low; pc frozen. Exited only by reset.
- acc_src_out = 00 outside EXEC of LDI/ADD/SUB/IN.
- At most one of ir_set_out, acc_set_out, out_set_out is high in any cycle.

## Timing
- Reset (asynchronous assert, synchronous to clock on release): state IDLE, pc 0, IR 0, all strobes 0, acc_src 00, operand 0, halted 0.
- Reset asserted mid-FETCH or mid-EXEC: outputs go to reset values immediately, with no partial strobe afterwards.
- Instruction latency is 2 cycles from FETCH entry to the next FETCH entry.
- A strobe is high for exactly one cycle. The target register captures on the rising edge that ends EXEC.
- pc_out changes on the edge leaving EXEC. instr_in must be valid during the FETCH cycle at the current pc_out.
- run_in deassert is honoured only in IDLE and at EXEC exit; an instruction in progress always completes.

## Test plan
- Reset: hold reset_n_in=0, toggle clock -> state 00, pc 0, all strobes 0. Release with run_in=0 -> stays IDLE.
- Program LDI 5 (0x15), ADD 3 (0x23), OUT (0x50), run_in=1:
  - ir_set high in cycles 1, 3, 5.
  - acc_set with src 00 / operand 5, then src 01 / operand 3.
  - out_set in cycle 6.
  - pc steps 0,1,2,3.
- JMP 0xA at pc 2 -> next FETCH at pc 10. JZ 4 with acc_zero=0 -> pc+1; with acc_zero=1 -> pc 4.
- NOP at pc 15 -> pc wraps to 0. Opcode 0xB behaves as NOP.
- HLT (0xF0) -> state 11, halted 1, pc unchanged; stays halted with run_in toggling until reset.
- Drop run_in during FETCH -> EXEC completes, then IDLE. Assert reset during EXEC of ADD -> acc_set drops the same cycle, pc 0.

Source files
------------

// File: rtl/ctrl_seq.sv
// ctrl_seq: two-cycle fetch/execute sequencer for the 4-bit accumulator datapath.
// Ports: clock_in/reset_n_in, run_in level enable, instr_in program word at pc_out,
//   acc_zero_in flag; pc_out, ir/acc/out set strobes, acc_src_out, operand_out,
//   state_out (IDLE/FETCH/EXEC/HALT) and halted_out.
module ctrl_seq #(
    parameter int DATA_WIDTH = 4,
    parameter int PC_WIDTH   = 4
) (
    input  logic                  clock_in,
    input  logic                  reset_n_in,
    input  logic                  run_in,
    input  logic [7:0]            instr_in,
    input  logic                  acc_zero_in,
    output logic [PC_WIDTH-1:0]   pc_out,
    output logic                  ir_set_out,
    output logic                  acc_set_out,
    output logic [1:0]            acc_src_out,
    output logic                  out_set_out,
    output logic [DATA_WIDTH-1:0] operand_out,
    output logic [1:0]            state_out,
    output logic                  halted_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_HALT  = 2'b11
    } state_e;

    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_IN  = 4'h4;
    localparam logic [3:0] OP_OUT = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [7:0]          ir_q, ir_d;

    logic [3:0]          opcode;
    logic [PC_WIDTH-1:0] jump_pc;
    logic [PC_WIDTH-1:0] pc_inc;

    logic                ir_set;
    logic                acc_set;
    logic [1:0]          acc_src;
    logic                out_set;

    assign opcode  = ir_q[7:4];
    // Operand field is zero-extended or truncated to the target width.
    assign jump_pc = PC_WIDTH'(ir_q[3:0]);
    assign pc_inc  = pc_q + PC_WIDTH'(1);

    // Strobes are decoded combinationally from the state register so an
    // asynchronous reset removes them in the same cycle.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ir_set  = 1'b0;
        acc_set = 1'b0;
        acc_src = 2'b00;
        out_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run_in) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                ir_set  = 1'b1;
                ir_d    = instr_in;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                pc_d    = pc_inc;
                state_d = run_in ? ST_FETCH : ST_IDLE;
                case (opcode)
                    OP_LDI: begin
                        acc_set = 1'b1;
                        acc_src = 2'b00;
                    end
                    OP_ADD: begin
                        acc_set = 1'b1;
                        acc_src = 2'b01;
                    end
                    OP_SUB: begin
                        acc_set = 1'b1;
                        acc_src = 2'b10;
                    end
                    OP_IN: begin
                        acc_set = 1'b1;
                        acc_src = 2'b11;
                    end
                    OP_OUT: begin
                        out_set = 1'b1;
                    end
                    OP_JMP: begin
                        pc_d = jump_pc;
                    end
                    OP_JZ: begin
                        if (acc_zero_in) begin
                            pc_d = jump_pc;
                        end
                    end
                    OP_HLT: begin
                        pc_d    = pc_q;
                        state_d = ST_HALT;
                    end
                    default: begin
                    end
                endcase
            end
            ST_HALT: begin
                // Sticky until reset; pc stays frozen.
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    assign pc_out      = pc_q;
    assign ir_set_out  = ir_set;
    assign acc_set_out = acc_set;
    assign acc_src_out = acc_src;
    assign out_set_out = out_set;
    assign operand_out = DATA_WIDTH'(ir_q[3:0]);
    assign state_out   = state_q;
    assign halted_out  = (state_q == ST_HALT);

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: directed self-checking bench for ctrl_seq.
// A small program memory feeds instr_in from pc_out; each task checks a scenario.
module tb_ctrl_seq;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic [7:0] instr;
    logic       az;
    logic [3:0] pc;
    logic       ir_set;
    logic       acc_set;
    logic [1:0] acc_src;
    logic       out_set;
    logic [3:0] operand;
    logic [1:0] state;
    logic       halted;

    logic [7:0] mem [16];

    int checks = 0;
    int errors = 0;

    ctrl_seq #(.DATA_WIDTH(4), .PC_WIDTH(4)) dut (
        .clock_in   (clk),
        .reset_n_in (rst_n),
        .run_in     (run),
        .instr_in   (instr),
        .acc_zero_in(az),
        .pc_out     (pc),
        .ir_set_out (ir_set),
        .acc_set_out(acc_set),
        .acc_src_out(acc_src),
        .out_set_out(out_set),
        .operand_out(operand),
        .state_out  (state),
        .halted_out (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb instr = mem[pc];

    // Observed bundle: state, pc, ir_set, acc_set, acc_src, out_set, operand, halted
    logic [15:0] obs;
    assign obs = {state, pc, ir_set, acc_set, acc_src, out_set, operand, halted};

    typedef struct packed {
        logic        run;
        logic        az;
        logic [15:0] exp;
    } vec_t;

    function automatic logic [15:0] ex(input logic [1:0] st, input logic [3:0] p,
                                       input logic i, input logic a,
                                       input logic [1:0] s, input logic o,
                                       input logic [3:0] op, input logic h);
        return {st, p, i, a, s, o, op, h};
    endfunction

    function automatic vec_t v(input logic r, input logic z, input logic [15:0] e);
        vec_t t;
        t.run = r;
        t.az  = z;
        t.exp = e;
        return t;
    endfunction

    task automatic load_mem(input logic [7:0] a0, input logic [7:0] w0,
                            input logic [7:0] a1, input logic [7:0] w1,
                            input logic [7:0] a2, input logic [7:0] w2);
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[a0[3:0]] = w0;
        mem[a1[3:0]] = w1;
        mem[a2[3:0]] = w2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run   = 1'b0;
        az    = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        run   = 1'b0;
        az    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (obs !== 16'h0000) begin
            errors++;
            $display("FAIL reset_hold got %h exp %h", obs, 16'h0000);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (obs !== 16'h0000) begin
            errors++;
            $display("FAIL reset_idle got %h exp %h", obs, 16'h0000);
        end
    endtask

    task automatic test_program();
        vec_t tab[7];
        load_mem(8'd0, 8'h15, 8'd1, 8'h23, 8'd2, 8'h50);
        do_reset();
        tab[0] = v(1, 0, ex(2'b01, 4'd0, 1, 0, 2'b00, 0, 4'h0, 0));
        tab[1] = v(1, 0, ex(2'b10, 4'd0, 0, 1, 2'b00, 0, 4'h5, 0));
        tab[2] = v(1, 0, ex(2'b01, 4'd1, 1, 0, 2'b00, 0, 4'h5, 0));
        tab[3] = v(1, 0, ex(2'b10, 4'd1, 0, 1, 2'b01, 0, 4'h3, 0));
        tab[4] = v(1, 0, ex(2'b01, 4'd2, 1, 0, 2'b00, 0, 4'h3, 0));
        tab[5] = v(1, 0, ex(2'b10, 4'd2, 0, 0, 2'b00, 1, 4'h0, 0));
        tab[6] = v(1, 0, ex(2'b01, 4'd3, 1, 0, 2'b00, 0, 4'h0, 0));
        for (int i = 0; i < 7; i++) begin
            run = tab[i].run;
            az  = tab[i].az;
            @(posedge clk); #1;
            checks++;
            if (obs !== tab[i].exp) begin
                errors++;
                $display("FAIL program step %0d got %h exp %h", i, obs, tab[i].exp);
            end
            checks++;
            if ((32'(ir_set) + 32'(acc_set) + 32'(out_set)) > 1) begin
                errors++;
                $display("FAIL onehot step %0d got %b%b%b exp at most one", i,
                         ir_set, acc_set, out_set);
            end
        end
    endtask

    task automatic test_jump();
        vec_t tab[11];
        load_mem(8'd2, 8'h6A, 8'd10, 8'h74, 8'd11, 8'h74);
        do_reset();
        tab[0]  = v(1, 0, ex(2'b01, 4'd0,  1, 0, 2'b00, 0, 4'h0, 0));
        tab[1]  = v(1, 0, ex(2'b10, 4'd0,  0, 0, 2'b00, 0, 4'h0, 0));
        tab[2]  = v(1, 0, ex(2'b01, 4'd1,  1, 0, 2'b00, 0, 4'h0, 0));
        tab[3]  = v(1, 0, ex(2'b10, 4'd1,  0, 0, 2'b00, 0, 4'h0, 0));
        tab[4]  = v(1, 0, ex(2'b01, 4'd2,  1, 0, 2'b00, 0, 4'h0, 0));
        tab[5]  = v(1, 0, ex(2'b10, 4'd2,  0, 0, 2'b00, 0, 4'hA, 0));
        tab[6]  = v(1, 0, ex(2'b01, 4'd10, 1, 0, 2'b00, 0, 4'hA, 0));
        tab[7]  = v(1, 0, ex(2'b10, 4'd10, 0, 0, 2'b00, 0, 4'h4, 0));
        tab[8]  = v(1, 0, ex(2'b01, 4'd11, 1, 0, 2'b00, 0, 4'h4, 0));
        tab[9]  = v(1, 1, ex(2'b10, 4'd11, 0, 0, 2'b00, 0, 4'h4, 0));
        tab[10] = v(1, 1, ex(2'b01, 4'd4,  1, 0, 2'b00, 0, 4'h4, 0));
        for (int i = 0; i < 11; i++) begin
            run = tab[i].run;
            az  = tab[i].az;
            @(posedge clk); #1;
            checks++;
            if (obs !== tab[i].exp) begin
                errors++;
                $display("FAIL jump step %0d got %h exp %h", i, obs, tab[i].exp);
            end
        end
    endtask

    task automatic test_wrap();
        vec_t tab[7];
        load_mem(8'd0, 8'h6E, 8'd14, 8'hB7, 8'd15, 8'h00);
        do_reset();
        tab[0] = v(1, 0, ex(2'b01, 4'd0,  1, 0, 2'b00, 0, 4'h0, 0));
        tab[1] = v(1, 0, ex(2'b10, 4'd0,  0, 0, 2'b00, 0, 4'hE, 0));
        tab[2] = v(1, 0, ex(2'b01, 4'd14, 1, 0, 2'b00, 0, 4'hE, 0));
        tab[3] = v(1, 0, ex(2'b10, 4'd14, 0, 0, 2'b00, 0, 4'h7, 0));
        tab[4] = v(1, 0, ex(2'b01, 4'd15, 1, 0, 2'b00, 0, 4'h7, 0));
        tab[5] = v(1, 0, ex(2'b10, 4'd15, 0, 0, 2'b00, 0, 4'h0, 0));
        tab[6] = v(1, 0, ex(2'b01, 4'd0,  1, 0, 2'b00, 0, 4'h0, 0));
        for (int i = 0; i < 7; i++) begin
            run = tab[i].run;
            az  = tab[i].az;
            @(posedge clk); #1;
            checks++;
            if (obs !== tab[i].exp) begin
                errors++;
                $display("FAIL wrap step %0d got %h exp %h", i, obs, tab[i].exp);
            end
        end
    endtask

    task automatic test_halt();
        vec_t tab[9];
        load_mem(8'd0, 8'h11, 8'd1, 8'hF0, 8'd2, 8'h00);
        do_reset();
        tab[0] = v(1, 0, ex(2'b01, 4'd0, 1, 0, 2'b00, 0, 4'h0, 0));
        tab[1] = v(1, 0, ex(2'b10, 4'd0, 0, 1, 2'b00, 0, 4'h1, 0));
        tab[2] = v(1, 0, ex(2'b01, 4'd1, 1, 0, 2'b00, 0, 4'h1, 0));
        tab[3] = v(1, 0, ex(2'b10, 4'd1, 0, 0, 2'b00, 0, 4'h0, 0));
        tab[4] = v(1, 0, ex(2'b11, 4'd1, 0, 0, 2'b00, 0, 4'h0, 1));
        tab[5] = v(0, 0, ex(2'b11, 4'd1, 0, 0, 2'b00, 0, 4'h0, 1));
        tab[6] = v(1, 0, ex(2'b11, 4'd1, 0, 0, 2'b00, 0, 4'h0, 1));
        tab[7] = v(0, 1, ex(2'b11, 4'd1, 0, 0, 2'b00, 0, 4'h0, 1));
        tab[8] = v(1, 0, ex(2'b11, 4'd1, 0, 0, 2'b00, 0, 4'h0, 1));
        for (int i = 0; i < 9; i++) begin
            run = tab[i].run;
            az  = tab[i].az;
            @(posedge clk); #1;
            checks++;
            if (obs !== tab[i].exp) begin
                errors++;
                $display("FAIL halt step %0d got %h exp %h", i, obs, tab[i].exp);
            end
        end
        do_reset();
        checks++;
        if (obs !== 16'h0000) begin
            errors++;
            $display("FAIL halt_exit_reset got %h exp %h", obs, 16'h0000);
        end
    endtask

    task automatic test_run_drop();
        vec_t tab[4];
        load_mem(8'd0, 8'h23, 8'd1, 8'h00, 8'd2, 8'h00);
        do_reset();
        tab[0] = v(1, 0, ex(2'b01, 4'd0, 1, 0, 2'b00, 0, 4'h0, 0));
        tab[1] = v(0, 0, ex(2'b10, 4'd0, 0, 1, 2'b01, 0, 4'h3, 0));
        tab[2] = v(0, 0, ex(2'b00, 4'd1, 0, 0, 2'b00, 0, 4'h3, 0));
        tab[3] = v(0, 0, ex(2'b00, 4'd1, 0, 0, 2'b00, 0, 4'h3, 0));
        for (int i = 0; i < 4; i++) begin
            run = tab[i].run;
            az  = tab[i].az;
            @(posedge clk); #1;
            checks++;
            if (obs !== tab[i].exp) begin
                errors++;
                $display("FAIL run_drop step %0d got %h exp %h", i, obs, tab[i].exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        load_mem(8'd0, 8'h23, 8'd1, 8'h00, 8'd2, 8'h00);
        do_reset();
        run = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (obs !== ex(2'b10, 4'd0, 0, 1, 2'b01, 0, 4'h3, 0)) begin
            errors++;
            $display("FAIL mid_exec_pre got %h exp %h", obs,
                     ex(2'b10, 4'd0, 0, 1, 2'b01, 0, 4'h3, 0));
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 16'h0000) begin
            errors++;
            $display("FAIL mid_exec_reset got %h exp %h", obs, 16'h0000);
        end
        @(posedge clk); #1;
        checks++;
        if (obs !== 16'h0000) begin
            errors++;
            $display("FAIL mid_exec_hold got %h exp %h", obs, 16'h0000);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (obs !== ex(2'b01, 4'd0, 1, 0, 2'b00, 0, 4'h0, 0)) begin
            errors++;
            $display("FAIL mid_fetch_pre got %h exp %h", obs,
                     ex(2'b01, 4'd0, 1, 0, 2'b00, 0, 4'h0, 0));
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 16'h0000) begin
            errors++;
            $display("FAIL mid_fetch_reset got %h exp %h", obs, 16'h0000);
        end
        run = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        run   = 1'b0;
        az    = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        test_reset();
        test_program();
        test_jump();
        test_wrap();
        test_halt();
        test_run_drop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
